axi_read_addr_arbiter: RTL and testbench
========================================

Name: axi_read_addr_arbiter

Overview:
- Read-address (AR) stage of the 2-master / 6-slave AXI interconnect, directly upstream of the read-data mux.
- Arbitrates AR requests from M0 (IF) and M1 (MEM), decodes the target slave and forwards the AR beat to it.
- Holds the grant until the RLAST handshake of that burst on the master side.
- Produces the 4-bit route code AR_arbiter and the 2-bit state cs that the read-data mux consumes.

Parameters:
- ADDR_W, 32, address width.
- ID_W, 4, master-side ID width; slave-side ID width is ID_W+4.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous active-high reset.
- ARID_M0/ARID_M1  in  ID_W  master AR ID.
- ARADDR_M0/ARADDR_M1  in  ADDR_W  address.
- ARLEN_M0/ARLEN_M1  in  4  burst length-1.
- ARSIZE_M0/ARSIZE_M1  in  3  beat size.
- ARBURST_M0/ARBURST_M1  in  2  burst type.
- ARVALID_M0/ARVALID_M1  in  1  request valid.
- ARREADY_M0/ARREADY_M1  out  1  request accepted.
- ARID_S  out  ID_W+4  shared slave ID: {4'h1,ARID} for M0, {4'h2,ARID} for M1.
- ARADDR_S / ARLEN_S / ARSIZE_S / ARBURST_S  out  ADDR_W/4/3/2  shared slave AR fields.
- ARVALID_S0..ARVALID_S5, ARVALID_SD  out  1  per-slave valid; SD is the default slave.
- ARREADY_S0..ARREADY_S5, ARREADY_SD  in  1  per-slave ready.
- RVALID_M0/RVALID_M1, RREADY_M0/RREADY_M1, RLAST_M0/RLAST_M1  in  1  master-side R handshake, observed for release.
- AR_arbiter  out  4  route code; [3:1] = slave+1 (1..6), 7 = default slave, 0 = idle; [0] = master.
- cs  out  2  state: 0 IDLE, 1 ADDR, 2 DATA.

Behaviour:
- Reset (async, immediate): cs=0, AR_arbiter=0, all ARREADY_M*/ARVALID_S* = 0, slave fields = 0, RR pointer favours M0.
- Decode:
  - S0: 0x0000_0000-0x0000_3FFF
  - S1: 0x0001_0000-0x0001_FFFF
  - S2: 0x0002_0000-0x0002_FFFF
  - S3: 0x1000_0000-0x1000_03FF
  - S4: 0x1001_0000-0x1001_03FF
  - S5: 0x2000_0000-0x201F_FFFF
  - Anything else goes to SD.
- IDLE:
  - AR_arbiter=0.
  - If any ARVALID_M*, select the winner and register its fields, decoded slave and code; next state ADDR.
  - No ARREADY_M in IDLE.
- ADDR:
  - Exactly one ARVALID_S* = 1, driven from registers; first asserted the cycle after the request is seen.
  - On ARREADY_Sx: ARREADY_M(winner)=1 combinationally in that same cycle (single-cycle pulse); next state DATA.
  - Fields held stable until accepted.
- DATA:
  - AR_arbiter and cs held.
  - On RVALID_Mw & RREADY_Mw & RLAST_Mw: next state IDLE; RR pointer moves to the other master.
  - Earliest new grant is evaluated the following cycle, so there are 2 idle-to-accept cycles minimum.
- Simultaneous requests in IDLE: the RR pointer decides.
- The loser's ARVALID is held pending; it is never acknowledged until it is served.
- cs=3 (illegal) forces IDLE on the next edge.
- Grant changes only in IDLE; a master deasserting ARVALID after capture is ignored (AXI violation, no recovery required).
- Non-winning ARREADY_M always 0.

Optional Feature:
- Macro: AR_TIMEOUT_EN.
- When defined:
  - An 8-bit counter runs in DATA and clears on each R beat handshake.
  - Reaching 255 forces IDLE and raises a sticky output TIMEOUT_ERR, cleared only by reset.
- When undefined: no counter, no TIMEOUT_ERR port; DATA waits indefinitely.

Test Plan:
- M0 ARVALID, ARADDR=0x0001_0040, ARID=3, ARLEN=0; ARREADY_S1 held 1 -> ARVALID_S1 at cycle+1, ARID_S=0x13, AR_arbiter=4'b0100, ARREADY_M0 pulse; release after one RLAST beat.
- M0 and M1 request the same cycle after reset -> M0 granted first (AR_arbiter=4'bxxx0); after its RLAST, M1 granted with code [0]=1.
- M1 ARADDR=0x3000_0000 -> ARVALID_SD=1, AR_arbiter=4'b1111; ARREADY_M1 only after ARREADY_SD.
- ARLEN=3 burst to S5 with RREADY_M0 toggling -> grant and cs=2 held for all 4 beats; IDLE only after the beat with RLAST.
- ARESET asserted mid-DATA -> cs=0, AR_arbiter=0, all valids 0 immediately, without waiting for a clock edge.
- With AR_TIMEOUT_EN: grant S3, never return RVALID -> after 255 cycles in DATA, cs=0 and TIMEOUT_ERR=1.

Source files
------------

// File: rtl/axi_read_addr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_addr_arbiter
// Brief    : AR-channel round-robin arbiter and address decoder for the
//            2-master / 6-slave AXI interconnect. The grant is held until the
//            winner's RLAST handshake. Optional macro AR_TIMEOUT_EN adds a
//            DATA-phase watchdog with a sticky TIMEOUT_ERR output.
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_addr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ID_W-1:0]   ARID_M0,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [3:0]        ARLEN_M0,
    input  logic [2:0]        ARSIZE_M0,
    input  logic [1:0]        ARBURST_M0,
    input  logic              ARVALID_M0,
    output logic              ARREADY_M0,
    input  logic [ID_W-1:0]   ARID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [3:0]        ARLEN_M1,
    input  logic [2:0]        ARSIZE_M1,
    input  logic [1:0]        ARBURST_M1,
    input  logic              ARVALID_M1,
    output logic              ARREADY_M1,
    output logic [ID_W+3:0]   ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [3:0]        ARLEN_S,
    output logic [2:0]        ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic              ARVALID_S0,
    output logic              ARVALID_S1,
    output logic              ARVALID_S2,
    output logic              ARVALID_S3,
    output logic              ARVALID_S4,
    output logic              ARVALID_S5,
    output logic              ARVALID_SD,
    input  logic              ARREADY_S0,
    input  logic              ARREADY_S1,
    input  logic              ARREADY_S2,
    input  logic              ARREADY_S3,
    input  logic              ARREADY_S4,
    input  logic              ARREADY_S5,
    input  logic              ARREADY_SD,
    input  logic              RVALID_M0,
    input  logic              RREADY_M0,
    input  logic              RLAST_M0,
    input  logic              RVALID_M1,
    input  logic              RREADY_M1,
    input  logic              RLAST_M1,
    output logic [3:0]        AR_arbiter,
`ifdef AR_TIMEOUT_EN
    output logic              TIMEOUT_ERR,
`endif
    output logic [1:0]        cs
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [2:0] c_SD   = 3'd6;

    // Slave index 0..5 for the mapped windows, 6 for the default slave
    function automatic logic [2:0] f_decode(input logic [ADDR_W-1:0] addr);
        logic [2:0] slv;
        slv = c_SD;
        if (addr <= ADDR_W'(32'h0000_3FFF))
            slv = 3'd0;
        else if (addr >= ADDR_W'(32'h0001_0000) && addr <= ADDR_W'(32'h0001_FFFF))
            slv = 3'd1;
        else if (addr >= ADDR_W'(32'h0002_0000) && addr <= ADDR_W'(32'h0002_FFFF))
            slv = 3'd2;
        else if (addr >= ADDR_W'(32'h1000_0000) && addr <= ADDR_W'(32'h1000_03FF))
            slv = 3'd3;
        else if (addr >= ADDR_W'(32'h1001_0000) && addr <= ADDR_W'(32'h1001_03FF))
            slv = 3'd4;
        else if (addr >= ADDR_W'(32'h2000_0000) && addr <= ADDR_W'(32'h201F_FFFF))
            slv = 3'd5;
        return slv;
    endfunction

    logic [1:0]        r_cs;
    logic [1:0]        w_cs_next;
    logic              r_master;
    logic              r_rr_ptr;
    logic [2:0]        r_slave;
    logic [ID_W+3:0]   r_arid_s;
    logic [ADDR_W-1:0] r_araddr;
    logic [3:0]        r_arlen;
    logic [2:0]        r_arsize;
    logic [1:0]        r_arburst;
    logic [3:0]        r_ar_arbiter;

    logic              w_any;
    logic              w_win;
    logic [2:0]        w_dec;
    logic [6:0]        w_svalid;
    logic [6:0]        w_sready;
    logic              w_s_ready;
    logic              w_r_beat;
    logic              w_r_last_hs;
    logic              w_timeout;

    assign w_any = ARVALID_M0 | ARVALID_M1;
    // The RR pointer only matters when both masters request together
    assign w_win = (ARVALID_M0 && ARVALID_M1) ? r_rr_ptr : ARVALID_M1;
    assign w_dec = f_decode(w_win ? ARADDR_M1 : ARADDR_M0);

    assign w_svalid  = (r_cs == c_ADDR) ? (7'd1 << r_slave) : 7'd0;
    assign w_sready  = {ARREADY_SD, ARREADY_S5, ARREADY_S4, ARREADY_S3,
                        ARREADY_S2, ARREADY_S1, ARREADY_S0};
    assign w_s_ready = |(w_svalid & w_sready);

    assign w_r_beat    = r_master ? (RVALID_M1 & RREADY_M1) : (RVALID_M0 & RREADY_M0);
    assign w_r_last_hs = w_r_beat & (r_master ? RLAST_M1 : RLAST_M0);

    always_comb begin
        w_cs_next = r_cs;
        case (r_cs)
            c_IDLE:  if (w_any) w_cs_next = c_ADDR;
            c_ADDR:  if (w_s_ready) w_cs_next = c_DATA;
            c_DATA:  if (w_r_last_hs || w_timeout) w_cs_next = c_IDLE;
            default: w_cs_next = c_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_cs <= c_IDLE;
        else        r_cs <= w_cs_next;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_master     <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_slave      <= 3'd0;
            r_arid_s     <= '0;
            r_araddr     <= '0;
            r_arlen      <= 4'd0;
            r_arsize     <= 3'd0;
            r_arburst    <= 2'd0;
            r_ar_arbiter <= 4'd0;
        end else begin
            if (r_cs == c_IDLE && w_any) begin
                r_master     <= w_win;
                r_slave      <= w_dec;
                r_ar_arbiter <= {w_dec + 3'd1, w_win};
                r_arid_s     <= w_win ? {4'h2, ARID_M1} : {4'h1, ARID_M0};
                r_araddr     <= w_win ? ARADDR_M1 : ARADDR_M0;
                r_arlen      <= w_win ? ARLEN_M1 : ARLEN_M0;
                r_arsize     <= w_win ? ARSIZE_M1 : ARSIZE_M0;
                r_arburst    <= w_win ? ARBURST_M1 : ARBURST_M0;
            end else if (w_cs_next == c_IDLE) begin
                r_ar_arbiter <= 4'd0;
            end
            if (r_cs == c_DATA && w_cs_next == c_IDLE)
                r_rr_ptr <= ~r_master;
        end
    end

`ifdef AR_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_timeout_err;

    // The counter would reach 255 on the edge that leaves DATA, so 255 DATA cycles max
    assign w_timeout = (r_cs == c_DATA) && !w_r_beat && (r_to_cnt == 8'd254);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_to_cnt      <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_cs != c_DATA || w_r_beat || w_timeout) r_to_cnt <= 8'd0;
            else                                         r_to_cnt <= r_to_cnt + 8'd1;
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign TIMEOUT_ERR = r_timeout_err;
`else
    assign w_timeout = 1'b0;
`endif

    assign ARREADY_M0 = w_s_ready & ~r_master;
    assign ARREADY_M1 = w_s_ready &  r_master;

    assign ARVALID_S0 = w_svalid[0];
    assign ARVALID_S1 = w_svalid[1];
    assign ARVALID_S2 = w_svalid[2];
    assign ARVALID_S3 = w_svalid[3];
    assign ARVALID_S4 = w_svalid[4];
    assign ARVALID_S5 = w_svalid[5];
    assign ARVALID_SD = w_svalid[6];

    assign ARID_S     = r_arid_s;
    assign ARADDR_S   = r_araddr;
    assign ARLEN_S    = r_arlen;
    assign ARSIZE_S   = r_arsize;
    assign ARBURST_S  = r_arburst;
    assign AR_arbiter = r_ar_arbiter;
    assign cs         = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_addr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_addr_arbiter
// Brief    : Self-checking bench for axi_read_addr_arbiter: vector table plus
//            hand-written multi-cycle sequences, AR acceptances scoreboarded.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_read_addr_arbiter;

    typedef struct {
        bit          m;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [3:0]  len;
        int          slave;
        logic [3:0]  code;
    } ar_vec_t;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1;
    logic        ARREADY_M0, ARREADY_M1;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S0, ARVALID_S1, ARVALID_S2, ARVALID_S3, ARVALID_S4, ARVALID_S5, ARVALID_SD;
    logic        ARREADY_S0, ARREADY_S1, ARREADY_S2, ARREADY_S3, ARREADY_S4, ARREADY_S5, ARREADY_SD;
    logic        RVALID_M0, RREADY_M0, RLAST_M0, RVALID_M1, RREADY_M1, RLAST_M1;
    logic [3:0]  AR_arbiter;
    logic [1:0]  cs;
`ifdef AR_TIMEOUT_EN
    logic        TIMEOUT_ERR;
`endif

    logic [6:0]  sv, sr;
    assign sv = {ARVALID_SD, ARVALID_S5, ARVALID_S4, ARVALID_S3, ARVALID_S2, ARVALID_S1, ARVALID_S0};
    assign sr = {ARREADY_SD, ARREADY_S5, ARREADY_S4, ARREADY_S3, ARREADY_S2, ARREADY_S1, ARREADY_S0};

    int      n_checks = 0;
    int      n_fail   = 0;
    ar_vec_t sb_q[$];
    ar_vec_t mon_e;
    ar_vec_t vecs[9];

    axi_read_addr_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S),
        .ARVALID_S0(ARVALID_S0), .ARVALID_S1(ARVALID_S1), .ARVALID_S2(ARVALID_S2),
        .ARVALID_S3(ARVALID_S3), .ARVALID_S4(ARVALID_S4), .ARVALID_S5(ARVALID_S5),
        .ARVALID_SD(ARVALID_SD),
        .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1), .ARREADY_S2(ARREADY_S2),
        .ARREADY_S3(ARREADY_S3), .ARREADY_S4(ARREADY_S4), .ARREADY_S5(ARREADY_S5),
        .ARREADY_SD(ARREADY_SD),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1), .RLAST_M1(RLAST_M1),
        .AR_arbiter(AR_arbiter),
`ifdef AR_TIMEOUT_EN
        .TIMEOUT_ERR(TIMEOUT_ERR),
`endif
        .cs(cs)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input bit m, input logic [31:0] addr, input logic [3:0] id,
                            input logic [3:0] len, input int slave, input logic [3:0] code);
        ar_vec_t e;
        e = '{m, addr, id, len, slave, code};
        sb_q.push_back(e);
    endtask

    task automatic set_ar(input bit m, input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len);
        if (!m) begin
            ARVALID_M0 = 1'b1; ARADDR_M0 = addr; ARID_M0 = id; ARLEN_M0 = len;
            ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01;
        end else begin
            ARVALID_M1 = 1'b1; ARADDR_M1 = addr; ARID_M1 = id; ARLEN_M1 = len;
            ARSIZE_M1 = 3'd3; ARBURST_M1 = 2'b10;
        end
    endtask

    task automatic drive_ar(input bit m, input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len);
        @(posedge ACLK); #1;
        set_ar(m, addr, id, len);
    endtask

    task automatic drop_ar(input bit m);
        @(posedge ACLK); #1;
        if (!m) ARVALID_M0 = 1'b0;
        else    ARVALID_M1 = 1'b0;
    endtask

    task automatic wait_arready(input bit m);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge ACLK);
            if (m ? ARREADY_M1 : ARREADY_M0) ok = 1'b1;
        end
        chk("arready_seen", ok, 1'b1);
    endtask

    // Returns `beats` R beats on master m; grant and DATA state must hold throughout
    task automatic r_burst(input bit m, input int beats, input bit toggle, input logic [3:0] code);
        int  b;
        int  cyc;
        logic rdy;
        b = 0;
        cyc = 0;
        while (b < beats && cyc < 100) begin
            @(posedge ACLK); #1;
            rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            if (!m) begin RVALID_M0 = 1'b1; RREADY_M0 = rdy; RLAST_M0 = (b == beats - 1); end
            else    begin RVALID_M1 = 1'b1; RREADY_M1 = rdy; RLAST_M1 = (b == beats - 1); end
            @(negedge ACLK);
            chk("data_cs_hold", cs, 2'd2);
            chk("data_code_hold", AR_arbiter, code);
            if (rdy) b++;
            cyc++;
        end
        @(posedge ACLK); #1;
        RVALID_M0 = 1'b0; RREADY_M0 = 1'b0; RLAST_M0 = 1'b0;
        RVALID_M1 = 1'b0; RREADY_M1 = 1'b0; RLAST_M1 = 1'b0;
        @(negedge ACLK);
        chk("release_cs_idle", cs, 2'd0);
        chk("release_code_zero", AR_arbiter, 4'd0);
    endtask

    // Scoreboard: every slave-side AR handshake must match the oldest expected request
    always @(negedge ACLK) begin
        if (!ARESET && ((sv & sr) != 7'd0)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_accept", 1'b1, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_slave_onehot", sv, 64'd1 << mon_e.slave);
                chk("sb_arid_s", ARID_S, {(mon_e.m ? 4'h2 : 4'h1), mon_e.id});
                chk("sb_araddr", ARADDR_S, mon_e.addr);
                chk("sb_arlen", ARLEN_S, mon_e.len);
                chk("sb_arsize", ARSIZE_S, mon_e.m ? 3'd3 : 3'd2);
                chk("sb_arburst", ARBURST_S, mon_e.m ? 2'b10 : 2'b01);
                chk("sb_code", AR_arbiter, mon_e.code);
                chk("sb_cs_addr", cs, 2'd1);
                chk("sb_arready_m", {ARREADY_M1, ARREADY_M0}, mon_e.m ? 2'b10 : 2'b01);
            end
        end
    end

    initial begin
        int n;
        ARESET = 1'b1;
        ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = '0; ARBURST_M0 = '0; ARVALID_M0 = 1'b0;
        ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = '0; ARBURST_M1 = '0; ARVALID_M1 = 1'b0;
        {ARREADY_SD, ARREADY_S5, ARREADY_S4, ARREADY_S3, ARREADY_S2, ARREADY_S1, ARREADY_S0} = 7'h7F;
        RVALID_M0 = 1'b0; RREADY_M0 = 1'b0; RLAST_M0 = 1'b0;
        RVALID_M1 = 1'b0; RREADY_M1 = 1'b0; RLAST_M1 = 1'b0;

        vecs[0] = '{1'b0, 32'h0001_0040, 4'h3, 4'd0, 1, 4'b0100};
        vecs[1] = '{1'b1, 32'h0000_3FFC, 4'h7, 4'd1, 0, 4'b0011};
        vecs[2] = '{1'b0, 32'h0000_4000, 4'h0, 4'd0, 6, 4'b1110};
        vecs[3] = '{1'b1, 32'h0002_FFFF, 4'hF, 4'd2, 2, 4'b0111};
        vecs[4] = '{1'b0, 32'h1000_03FF, 4'h4, 4'd0, 3, 4'b1000};
        vecs[5] = '{1'b1, 32'h1000_0400, 4'h6, 4'd0, 6, 4'b1111};
        vecs[6] = '{1'b0, 32'h1001_0000, 4'h8, 4'd1, 4, 4'b1010};
        vecs[7] = '{1'b1, 32'h201F_FFFF, 4'hC, 4'd0, 5, 4'b1101};
        vecs[8] = '{1'b0, 32'h2020_0000, 4'hB, 4'd0, 6, 4'b1110};

        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_cs", cs, 2'd0);
        chk("rst_code", AR_arbiter, 4'd0);
        chk("rst_svalid", sv, 7'd0);
        chk("rst_mready", {ARREADY_M1, ARREADY_M0}, 2'b00);
        chk("rst_fields", {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}, 49'd0);
`ifdef AR_TIMEOUT_EN
        chk("rst_timeout_err", TIMEOUT_ERR, 1'b0);
`endif

        // Single-request table: decode boundaries and route codes for both masters
        for (int i = 0; i < 9; i++) begin
            push_exp(vecs[i].m, vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].slave, vecs[i].code);
            drive_ar(vecs[i].m, vecs[i].addr, vecs[i].id, vecs[i].len);
            @(negedge ACLK);
            chk("idle_no_svalid", sv, 7'd0);
            chk("idle_no_mready", {ARREADY_M1, ARREADY_M0}, 2'b00);
            wait_arready(vecs[i].m);
            drop_ar(vecs[i].m);
            r_burst(vecs[i].m, int'(vecs[i].len) + 1, 1'b0, vecs[i].code);
        end

        // Default slave with a slow ready: no master ack until ARREADY_SD
        ARREADY_SD = 1'b0;
        push_exp(1'b1, 32'h3000_0000, 4'h5, 4'd0, 6, 4'b1111);
        drive_ar(1'b1, 32'h3000_0000, 4'h5, 4'd0);
        @(negedge ACLK);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("sd_wait_valid", ARVALID_SD, 1'b1);
            chk("sd_wait_code", AR_arbiter, 4'b1111);
            chk("sd_wait_mready", ARREADY_M1, 1'b0);
        end
        @(posedge ACLK); #1 ARREADY_SD = 1'b1;
        wait_arready(1'b1);
        drop_ar(1'b1);
        r_burst(1'b1, 1, 1'b0, 4'b1111);

        // 4-beat burst to S5 with RREADY toggling
        push_exp(1'b0, 32'h2000_1000, 4'h7, 4'd3, 5, 4'b1100);
        drive_ar(1'b0, 32'h2000_1000, 4'h7, 4'd3);
        wait_arready(1'b0);
        drop_ar(1'b0);
        r_burst(1'b0, 4, 1'b1, 4'b1100);

        // Asynchronous reset in the middle of DATA
        push_exp(1'b1, 32'h1001_0200, 4'h9, 4'd0, 4, 4'b1011);
        drive_ar(1'b1, 32'h1001_0200, 4'h9, 4'd0);
        wait_arready(1'b1);
        drop_ar(1'b1);
        chk("pre_rst_cs_data", cs, 2'd2);
        #2 ARESET = 1'b1;
        #1;
        chk("async_rst_cs", cs, 2'd0);
        chk("async_rst_code", AR_arbiter, 4'd0);
        chk("async_rst_svalid", sv, 7'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;

        // Simultaneous requests after reset: M0 first, then M1
        push_exp(1'b0, 32'h0000_0100, 4'h1, 4'd0, 0, 4'b0010);
        push_exp(1'b1, 32'h0002_0000, 4'hA, 4'd0, 2, 4'b0111);
        @(posedge ACLK); #1;
        set_ar(1'b0, 32'h0000_0100, 4'h1, 4'd0);
        set_ar(1'b1, 32'h0002_0000, 4'hA, 4'd0);
        wait_arready(1'b0);
        drop_ar(1'b0);
        r_burst(1'b0, 1, 1'b0, 4'b0010);
        wait_arready(1'b1);
        drop_ar(1'b1);
        r_burst(1'b1, 1, 1'b0, 4'b0111);

`ifdef AR_TIMEOUT_EN
        // Grant S3 and never return data
        push_exp(1'b0, 32'h1000_0000, 4'h2, 4'd0, 3, 4'b1000);
        drive_ar(1'b0, 32'h1000_0000, 4'h2, 4'd0);
        wait_arready(1'b0);
        drop_ar(1'b0);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge ACLK);
            if (cs != 2'd2) break;
            n++;
        end
        chk("timeout_data_cycles", n, 255);
        chk("timeout_cs_idle", cs, 2'd0);
        chk("timeout_err_set", TIMEOUT_ERR, 1'b1);
        repeat (3) @(negedge ACLK);
        chk("timeout_err_sticky", TIMEOUT_ERR, 1'b1);
`else
        n = 0;
`endif

        repeat (2) @(negedge ACLK);
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
